apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer that sits directly downstream of the team's APB master: it decodes the master's encoded 4-bit slave select, runs the slave side of the SETUP/ACCESS handshake with a parameterised number of wait states, and backs the transfers with a word-addressed register file. Register 0 is a read-only ID register. Illegal accesses complete with PSLVERR and have no side effects.

## Interface
- `WIDTH`, 32: address and data width.
- `DEPTH`, 16: number of 32-bit words; power of two, 2..256.
- `SLV_ID`, 1: encoded select value this slave answers to; legal range 1..15, because 0 means "no slave".
- `WAIT_CYCLES`, 0: number of ACCESS cycles with PREADY low before completion; legal range 0..15.
- `ID_VALUE`, 32'hA9B0_0001: constant returned by reads of word 0.

Ports:
- `pclk`  in  1: clock; all state changes on its rising edge.
- `preset`  in  1: reset, synchronous and active-high.
- `paddr`  in  WIDTH: byte address.
- `pwdata`  in  WIDTH: write data.
- `pselx`  in  4: encoded slave select.
- `penable`  in  1: ACCESS phase indicator.
- `pwrite`  in  1: 1 = write, 0 = read.
- `pready`  out  1: transfer completes in this cycle.
- `prdata`  out  WIDTH: read data; valid only while `pready` is high on a read.
- `pslverr`  out  1: error response; valid only while `pready` is high.

## Operation
- `sel = (pselx == SLV_ID)`.
- FSM states, held in a 2-bit enum: IDLE, ACCESS.
- **IDLE**
  - When `sel && !penable` (the SETUP cycle), capture `paddr`, `pwrite` and `pwdata` into holding registers.
  - Load `wcnt <= WAIT_CYCLES` and compute the error flag.
  - For reads, register the addressed word into `rd_q`.
  - Go to ACCESS.
- **Error conditions**, evaluated in SETUP:
  - `paddr[1:0] != 0`, or
  - word index `paddr >> 2 >= DEPTH`, or any upper address bit set, or
  - a write to word 0.
- **ACCESS, while `sel && penable`**
  - If `wcnt != 0`, decrement `wcnt` and stay in ACCESS.
  - If `wcnt == 0`, the cycle is the completion cycle: `pready = 1`. At the closing edge:
    - commit a write if there is no error,
    - return to IDLE.
- **ACCESS, protocol violation** (`!sel` or `!penable`): abort. Return to IDLE with no write and no pready pulse.
- **Outputs**
  - `pready = (state == ACCESS) && (wcnt == 0) && sel && penable`. It is combinational from registered state, as the master samples it in the same cycle.
  - `pslverr = pready && err_q`.
  - `prdata = (pready && !pwrite_q && !err_q) ? rd_q : 0`.
- **Read and write semantics**
  - Word 0 always reads `ID_VALUE`.
  - Writes store the full word; there is no byte strobe.
- **Back-to-back transfers:** the master's ACCESS→SETUP path puts SETUP in the cycle right after completion. Because the FSM is in IDLE in that cycle, the new transfer is captured with no bubble.

## Timing
- Reset, while `preset` is high at a clock edge:
  - state goes to IDLE, `wcnt` to 0, `err_q`/`rd_q` to 0,
  - words 1..DEPTH-1 are cleared to 0,
  - outputs `pready`/`pslverr`/`prdata` are 0 in the following cycle.
- Reset asserted mid-transfer: the transfer is dropped with no commit. The master must restart.
- Latency:
  - SETUP occupies 1 cycle.
  - ACCESS occupies `WAIT_CYCLES + 1` cycles, with `pready` high in the last one only.
  - A write is visible to a read whose SETUP starts on the cycle after completion.
- Read data is the register value at the SETUP edge. A write completing in the same cycle as a read's SETUP cannot occur, since the protocol is single-outstanding.
- `pready` is never high outside ACCESS, and never high for more than 1 consecutive cycle per transfer.

## Structure
- `apb_pkg` holds:
  - the state enum `apb_slv_state_t {SLV_IDLE, SLV_ACCESS}`,
  - a default `APB_WIDTH` localparam,
  - the `APB_NO_SLAVE = 4'd0` constant,
  - the error-code helper function `apb_addr_err(addr, depth)`.
- One sub-module, `apb_slv_regs`, contains storage, reset clearing, and the ID mux:
  - synchronous write port,
  - read port registered on capture,
  - word 0 constant.
- The top level contains the FSM, wait counter, decode and output gating.

## Test plan
- **Reset, then read word 0 with `WAIT_CYCLES=0`, `SLV_ID=1`:** `pready` high in the first ACCESS cycle, `prdata=32'hA9B0_0001`, `pslverr=0`.
- **Write `32'hDEAD_BEEF` to `0x08`, then read `0x08` back-to-back** (ACCESS→SETUP, no IDLE): read returns `DEAD_BEEF` and no bubble cycle is inserted.
- **`WAIT_CYCLES=3`, write `0x04`:** `pready` low for exactly 3 ACCESS cycles, high on the 4th, and the write is committed only after that edge.
- **Error cases:** write to `0x00`, read `0x41` (misaligned), and read `0x40` with DEPTH=16 (out of range). Each completes with `pslverr=1` and `prdata=0`, and word 0 still reads `ID_VALUE`.
- **Other-slave and abort cases:**
  - `pselx=2` (another slave) with penable: `pready` stays 0 and there is no write.
  - Drop `penable` mid-ACCESS (`WAIT_CYCLES=2`): FSM aborts to IDLE with no commit.
- **Assert `preset` in the 2nd wait cycle of a write to `0x0C`:** outputs go to 0, the FSM is in IDLE, and a subsequent read of `0x0C` returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register file.
package apb_pkg;

  localparam int APB_WIDTH = 32;

  localparam logic [3:0] APB_NO_SLAVE = 4'd0;

  typedef enum logic [1:0] {
    SLV_IDLE   = 2'd0,
    SLV_ACCESS = 2'd1
  } apb_slv_state_t;

  // Flags a byte address that is misaligned or whose word index falls outside
  // the register file. Any set upper address bit pushes the index out of range.
  function automatic logic apb_addr_err(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/apb_slv_regs.sv
// Word-addressed storage for the APB completer. Word 0 is a constant ID.
// Writes are synchronous; the read port registers the addressed word at capture.
module apb_slv_regs
  import apb_pkg::*;
#(
  parameter int               WIDTH    = APB_WIDTH,
  parameter int               DEPTH    = 16,
  parameter logic [WIDTH-1:0] ID_VALUE = 32'hA9B0_0001,
  localparam int              IDX_W    = $clog2(DEPTH)
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage update: clear on reset, full-word writes to words 1..DEPTH-1, registered read with ID mux.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en && (wr_idx != '0)) begin
        mem[wr_idx] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= (rd_idx == '0) ? ID_VALUE : mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: decodes the encoded slave select, runs the SETUP/ACCESS
// handshake with a fixed number of wait states, and fronts apb_slv_regs.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               WIDTH       = APB_WIDTH,
  parameter int               DEPTH       = 16,
  parameter int               SLV_ID      = 1,
  parameter int               WAIT_CYCLES = 0,
  parameter logic [WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  input  logic [3:0]       pselx,
  input  logic             penable,
  input  logic             pwrite,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  output logic             pslverr
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_slv_state_t   state, next_state;
  logic [3:0]       wcnt;
  logic             err_q;
  logic             pwrite_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rd_q;

  logic             sel;
  logic             setup_err;
  logic             load;
  logic             dec;
  logic             commit;

  assign sel = (pselx == 4'(SLV_ID)) && (pselx != APB_NO_SLAVE);

  assign setup_err = apb_addr_err(64'(paddr), DEPTH) ||
                     (pwrite && (paddr[WIDTH-1:2] == '0));

  // Next-state and handshake decode: capture on SETUP, count waits, complete or abort in ACCESS.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    dec        = 1'b0;
    commit     = 1'b0;
    pready     = 1'b0;
    case (state)
      SLV_IDLE: begin
        if (sel && !penable) begin
          load       = 1'b1;
          next_state = SLV_ACCESS;
        end
      end
      SLV_ACCESS: begin
        if (sel && penable) begin
          if (wcnt != 4'd0) begin
            dec = 1'b1;
          end else begin
            pready     = 1'b1;
            commit     = pwrite_q && !err_q;
            next_state = SLV_IDLE;
          end
        end else begin
          next_state = SLV_IDLE;
        end
      end
      default: begin
        next_state = SLV_IDLE;
      end
    endcase
  end

  // State register plus holding registers loaded in SETUP and the wait counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= SLV_IDLE;
      wcnt     <= 4'd0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        idx_q    <= paddr[IDX_W+1:2];
        pwrite_q <= pwrite;
        wdata_q  <= pwdata;
        wcnt     <= 4'(WAIT_CYCLES);
        err_q    <= setup_err;
      end else if (dec) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  apb_slv_regs #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE)
  ) u_regs (
    .pclk    (pclk),
    .preset  (preset),
    .wr_en   (commit),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_en   (load && !pwrite),
    .rd_idx  (paddr[IDX_W+1:2]),
    .rd_data (rd_q)
  );

  assign pslverr = pready && err_q;
  assign prdata  = (pready && !pwrite_q && !err_q) ? rd_q : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: three completers on one APB bus with different
// select codes and wait counts, checked against a word-array model.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID_VAL = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pselx;
  logic        penable;
  logic        pwrite;

  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int slv_ids   [3] = '{1, 3, 4};
  int exp_waits [3] = '{0, 3, 2};

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [3][16];

  typedef struct {
    int          tgt;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.SLV_ID(1), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .pselx(pselx),
    .penable(penable), .pwrite(pwrite), .pready(pready_v[0]), .prdata(prdata_v[0]),
    .pslverr(pslverr_v[0])
  );

  apb_slave_regfile #(.SLV_ID(3), .WAIT_CYCLES(3)) dut1 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .pselx(pselx),
    .penable(penable), .pwrite(pwrite), .pready(pready_v[1]), .prdata(prdata_v[1]),
    .pslverr(pslverr_v[1])
  );

  apb_slave_regfile #(.SLV_ID(4), .WAIT_CYCLES(2)) dut2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .pselx(pselx),
    .penable(penable), .pwrite(pwrite), .pready(pready_v[2]), .prdata(prdata_v[2]),
    .pslverr(pslverr_v[2])
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic busIdle();
    pselx   = 4'd0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
  endtask

  task automatic clearModel();
    for (int t = 0; t < 3; t++)
      for (int w = 0; w < 16; w++)
        model_mem[t][w] = '0;
  endtask

  task automatic modelExpect(input int tgt, input logic wr, input logic [31:0] addr,
                             output logic [31:0] erd, output logic eerr);
    int idx;
    idx  = int'(addr >> 2);
    eerr = (addr % 4 != 0) || (addr >= 32'd64) || (wr && idx == 0);
    erd  = '0;
    if (!wr && !eerr) erd = (idx == 0) ? ID_VAL : model_mem[tgt][idx];
  endtask

  task automatic modelCommit(input int tgt, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
    logic [31:0] erd;
    logic        eerr;
    modelExpect(tgt, wr, addr, erd, eerr);
    if (wr && !eerr) model_mem[tgt][int'(addr >> 2)] = data;
  endtask

  // One full transfer starting right after a rising edge; returns right after the completion edge.
  task automatic applyStimulus(input int tgt, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata,
                               output logic err, output int waits, output bit done);
    pselx   = 4'(slv_ids[tgt]);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    rdata   = '0;
    err     = 1'b0;
    waits   = 0;
    done    = 1'b0;
    @(negedge pclk);
    checkOutput("setup_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      if (pready_v[tgt]) begin
        rdata = prdata_v[tgt];
        err   = pslverr_v[tgt];
        done  = 1'b1;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic runChecked(input string name, input int tgt, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          w;
    bit          dn;
    applyStimulus(tgt, wr, addr, data, rd, er, w, dn);
    checkOutput({name, "_done"}, 32'(dn), 32'd1);
    checkOutput({name, "_waits"}, 32'(w), 32'(exp_waits[tgt]));
    checkOutput({name, "_pslverr"}, 32'(er), 32'(exp_err));
    checkOutput({name, "_prdata"}, rd, exp_rd);
    modelCommit(tgt, wr, addr, data);
  endtask

  task automatic runModel(input string name, input int tgt, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] erd;
    logic        eerr;
    modelExpect(tgt, wr, addr, erd, eerr);
    runChecked(name, tgt, wr, addr, data, erd, eerr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
    int          tgt;
    int          kind;

    vecs[0]  = '{0, 1'b0, 32'h00,       32'h0,         ID_VAL,        1'b0};
    vecs[1]  = '{0, 1'b1, 32'h08,       32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{0, 1'b0, 32'h08,       32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{0, 1'b1, 32'h00,       32'h1234_5678, 32'h0,         1'b1};
    vecs[4]  = '{0, 1'b0, 32'h41,       32'h0,         32'h0,         1'b1};
    vecs[5]  = '{0, 1'b0, 32'h40,       32'h0,         32'h0,         1'b1};
    vecs[6]  = '{0, 1'b0, 32'h00,       32'h0,         ID_VAL,        1'b0};
    vecs[7]  = '{0, 1'b1, 32'h3C,       32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[8]  = '{0, 1'b0, 32'h3C,       32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{0, 1'b0, 32'h04,       32'h0,         32'h0,         1'b0};
    vecs[10] = '{0, 1'b1, 32'h8000_0008, 32'h1111_1111, 32'h0,        1'b1};
    vecs[11] = '{0, 1'b0, 32'h08,       32'h0,         32'hDEAD_BEEF, 1'b0};

    clearModel();
    busIdle();
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("reset_pready", 32'(pready_v), 32'd0);
    checkOutput("reset_pslverr", 32'(pslverr_v), 32'd0);
    for (int t = 0; t < 3; t++) checkOutput($sformatf("reset_prdata%0d", t), prdata_v[t], 32'd0);
    @(posedge pclk); #1;

    $display("[TB] table vectors, back-to-back on select 1");
    for (int i = 0; i < 12; i++) begin
      runChecked($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].wr, vecs[i].addr,
                 vecs[i].data, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    busIdle();
    @(posedge pclk); #1;

    $display("[TB] three wait states, single pready pulse");
    runChecked("wait3_wr", 1, 1'b1, 32'h04, 32'h0BAD_F00D, 32'h0, 1'b0);
    pselx   = 4'd3;
    penable = 1'b1;
    pwrite  = 1'b1;
    @(negedge pclk);
    checkOutput("wait3_no_second_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    busIdle();
    @(posedge pclk); #1;
    runChecked("wait3_rd", 1, 1'b0, 32'h04, 32'h0, 32'h0BAD_F00D, 1'b0);
    busIdle();
    @(posedge pclk); #1;

    $display("[TB] other slave select");
    pselx   = 4'd2;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hFFFF_FFFF;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      checkOutput($sformatf("other_slave_pready%0d", c), 32'(pready_v), 32'd0);
      @(posedge pclk); #1;
    end
    busIdle();
    @(posedge pclk); #1;
    for (int t = 0; t < 3; t++) runModel($sformatf("other_slave_rd%0d", t), t, 1'b0, 32'h10, 32'h0);
    busIdle();
    @(posedge pclk); #1;

    $display("[TB] penable dropped mid-access");
    pselx   = 4'd4;
    pwrite  = 1'b1;
    paddr   = 32'h08;
    pwdata  = 32'h1234_ABCD;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    checkOutput("abort_wait_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(negedge pclk);
    checkOutput("abort_drop_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    busIdle();
    @(negedge pclk);
    checkOutput("abort_idle_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    runModel("abort_rd", 2, 1'b0, 32'h08, 32'h0);
    busIdle();
    @(posedge pclk); #1;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      tgt  = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom;
      kind = int'($urandom_range(0, 9));
      if (kind <= 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (kind == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 8) a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
      else                a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      runModel($sformatf("rand%0d", n), tgt, wr, a, d);
      if ($urandom_range(0, 3) == 0) begin
        busIdle();
        @(posedge pclk); #1;
      end
    end
    busIdle();
    @(posedge pclk); #1;

    $display("[TB] reset during second wait cycle");
    runChecked("pre_reset_wr", 0, 1'b1, 32'h0C, 32'h7777_0000, 32'h0, 1'b0);
    busIdle();
    @(posedge pclk); #1;
    pselx   = 4'd3;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'h5555_AAAA;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("mid_reset_pready", 32'(pready_v), 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    busIdle();
    clearModel();
    @(negedge pclk);
    checkOutput("post_reset_pready", 32'(pready_v), 32'd0);
    checkOutput("post_reset_pslverr", 32'(pslverr_v), 32'd0);
    checkOutput("post_reset_prdata", prdata_v[1], 32'd0);
    @(posedge pclk); #1;
    runChecked("post_reset_rd_sel3", 1, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
    runChecked("post_reset_rd_sel1", 0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
    runChecked("post_reset_id", 2, 1'b0, 32'h00, 32'h0, ID_VAL, 1'b0);
    busIdle();
    @(posedge pclk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
